// File: rtl/pipe_elastic_reg.sv
// Elastic DEPTH-entry pipeline register with valid/ready handshake, flush and sticky halt.
// Optional statistics counters are enabled by defining PIPE_ELASTIC_REG_STATS_EN.
module pipe_elastic_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 2
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_halt,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_halt,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
`ifdef PIPE_ELASTIC_REG_STATS_EN
   output logic [31:0]              stall_cycles,
   output logic [15:0]              flush_count,
`endif
   output logic                     halted
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = DATA_W + 1;

   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rptr_q;
   logic [PTR_W-1:0] wptr_q;
   logic [CNT_W-1:0] count_q;
   logic             halted_q;
   logic             full;
   logic             push;
   logic             pop;

   // Handshake depends only on registered state, flush and reset; never on out_ready.
   assign full      = (count_q == CNT_W'(DEPTH));
   assign in_ready  = !full && !halted_q && !flush && !RST;
   assign out_valid = (count_q != '0) && !halted_q;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign {out_halt, out_data} = mem[rptr_q];
   assign count  = count_q;
   assign halted = halted_q;

   // Storage is cleared on reset so the head reads as zero out of reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rptr_q   <= '0;
         wptr_q   <= '0;
         count_q  <= '0;
         halted_q <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            mem[wptr_q] <= {in_halt, in_data};
            wptr_q      <= wptr_q + PTR_W'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PTR_W'(1);
            if (out_halt) begin
               halted_q <= 1'b1;
            end
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef PIPE_ELASTIC_REG_STATS_EN
   logic [31:0] stall_q;
   logic [15:0] flush_q;

   // Saturating counters of upstream stall cycles and flush cycles.
   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (in_valid && !in_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'(1);
         end
         if (flush && (flush_q != '1)) begin
            flush_q <= flush_q + 16'(1);
         end
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Randomised and directed bench for pipe_elastic_reg with a queue-based reference model
// and a scoreboard monitor on the output handshake.
module tb_pipe_elastic_reg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic              halt;
      logic [DATA_W-1:0] data;
   } ent_t;

   logic              CLK;
   logic              RST;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_halt;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_halt;
   logic              flush;
   logic [CNT_W-1:0]  count;
   logic              halted;
`ifdef PIPE_ELASTIC_REG_STATS_EN
   logic [31:0]       stall_cycles;
   logic [15:0]       flush_count;
   int unsigned       m_stall;
   int unsigned       m_flush;
`endif

   int   checks = 0;
   int   errors = 0;
   ent_t model_q[$];
   ent_t sb_q[$];
   bit   m_halted = 1'b0;

   pipe_elastic_reg #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_halt      (in_halt),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_halt     (out_halt),
      .flush        (flush),
      .count        (count),
`ifdef PIPE_ELASTIC_REG_STATS_EN
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count),
`endif
      .halted       (halted)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Reference model: contents as a FIFO queue, advanced once per cycle from the inputs.
   always @(negedge CLK) begin
      bit exp_rdy;
      bit exp_ov;
      if (RST) begin
         chk("in_ready_in_reset", 64'(in_ready), 64'(0));
         model_q.delete();
         sb_q.delete();
         m_halted = 1'b0;
`ifdef PIPE_ELASTIC_REG_STATS_EN
         m_stall = 0;
         m_flush = 0;
`endif
      end else begin
         exp_rdy = (model_q.size() < DEPTH) && !m_halted && !flush;
         exp_ov  = (model_q.size() != 0) && !m_halted;
         chk("in_ready",  64'(in_ready),  64'(exp_rdy));
         chk("out_valid", 64'(out_valid), 64'(exp_ov));
         chk("count",     64'(count),     64'(model_q.size()));
         chk("halted",    64'(halted),    64'(m_halted));
`ifdef PIPE_ELASTIC_REG_STATS_EN
         chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
         chk("flush_count",  64'(flush_count),  64'(m_flush));
         if (in_valid && !exp_rdy) m_stall++;
         if (flush) m_flush++;
`endif
         if (flush) begin
            model_q.delete();
            sb_q.delete();
         end else begin
            if (exp_ov && out_ready) begin
               if (model_q[0].halt) m_halted = 1'b1;
               void'(model_q.pop_front());
            end
            if (in_valid && exp_rdy) begin
               model_q.push_back('{halt: in_halt, data: in_data});
               sb_q.push_back('{halt: in_halt, data: in_data});
            end
         end
      end
   end

   // Scoreboard monitor: every handshake on the output must match the oldest expected word.
   always @(negedge CLK) begin
      #1;
      if (!RST && !flush && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got 0x%0h expected none at %0t", out_data, $time);
         end else begin
            chk("out_data", 64'(out_data), 64'(sb_q[0].data));
            chk("out_halt", 64'(out_halt), 64'(sb_q[0].halt));
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; in_valid = 1'b0; in_data = '0; in_halt = 1'b0;
      out_ready = 1'b0; flush = 1'b0;
      repeat (2) step();
      RST = 1'b0;
      @(negedge CLK);
      chk("reset_out_data", 64'(out_data), 64'(0));
      chk("reset_out_halt", 64'(out_halt), 64'(0));

      // Streaming with downstream always ready.
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = DATA_W'(i);
         step();
      end
      in_valid = 1'b0;
      repeat (3) step();

      // Backpressure until full, then release.
      out_ready = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         in_valid = 1'b1; in_data = DATA_W'(32'hA + i);
         step();
      end
      in_data = 32'hEE;
      repeat (2) step();
      @(negedge CLK);
      chk("full_count",    64'(count),    64'(DEPTH));
      chk("full_in_ready", 64'(in_ready), 64'(0));
      out_ready = 1'b1;
      repeat (2) step();
      in_valid = 1'b0;
      repeat (DEPTH + 2) step();

      // Random traffic with occasional flush.
      repeat (200) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         in_halt   = 1'b0;
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 29) == 0);
         step();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (DEPTH + 2) step();

      // Flush with a concurrent push.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = DATA_W'(32'h21 + i);
         step();
      end
      flush = 1'b1; in_data = 32'hF;
      step();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge CLK);
      chk("flush_count_zero", 64'(count),     64'(0));
      chk("flush_out_valid",  64'(out_valid), 64'(0));
      out_ready = 1'b1;
      repeat (4) step();

      // Halt word freezes the stage.
      in_valid = 1'b1; in_data = 32'h5; in_halt = 1'b0; step();
      in_data = 32'h6; in_halt = 1'b1; step();
      in_data = 32'h7; in_halt = 1'b0; step();
      in_data = 32'h8;
      repeat (3) step();
      in_valid = 1'b0;
      @(negedge CLK);
      chk("halt_halted",    64'(halted),    64'(1));
      chk("halt_out_valid", 64'(out_valid), 64'(0));
      chk("halt_in_ready",  64'(in_ready),  64'(0));
      RST = 1'b1;
      step();
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_in_ready",  64'(in_ready),  64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data",  64'(out_data),  64'(0));
      chk("rst_out_halt",  64'(out_halt),  64'(0));
      chk("rst_count",     64'(count),     64'(0));
      chk("rst_halted",    64'(halted),    64'(0));

`ifdef PIPE_ELASTIC_REG_STATS_EN
      // Five stalled cycles while full, then two flush pulses.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
      repeat (DEPTH + 5) step();
      in_valid = 1'b0;
      flush = 1'b1; step();
      flush = 1'b0; step();
      flush = 1'b1; step();
      flush = 1'b0; step();
      @(negedge CLK);
      chk("stats_stall", 64'(stall_cycles), 64'(5));
      chk("stats_flush", 64'(flush_count),  64'(2));
`endif

      repeat (2) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
